id_imm_queue: RTL and testbench
===============================

# id_imm_queue

Parametrised, buffered successor to the immediate-class decode slice in the ID stage. Decodes I-type ALU instructions, and optionally load/store instructions, from the instruction stream, reads the register operand, builds the extended immediate at DATA_WIDTH, and holds the result in a DEPTH-entry in-order queue. The queue sits between IF/ID and EX and decouples the two stages with valid/ready handshakes plus a flush for branch/exception redirects.

## Interface
- DATA_WIDTH, 32: operand and register-data width; must be at least 32.
- DEPTH, 2: queue entries; power of two, at least 2.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset (`RST_ENABLE`).
- flush  in  1  synchronously empties the queue.
- in_valid / in_ready  in / out  1 / 1  instruction handshake.
- inst  in  32  MIPS instruction word.
- reg_addr_1, reg_read_en_1  out  5, 1  rs read request to the RegReadProxy.
- reg_addr_2, reg_read_en_2  out  5, 1  rt read request; store instructions only.
- reg_val_mux_data_1/2  in  DATA_WIDTH  read data, returned combinationally in the same cycle.
- out_valid / out_ready  out / in  1 / 1  EX handshake.
- out_op  out  6  opcode of the head entry.
- out_inst_immediate  out  1  head entry is an I-type ALU instruction.
- out_mem  out  1  head entry is a load or store; constant 0 when the macro is absent.
- out_operand_1, out_operand_2, out_store_data  out  DATA_WIDTH  rs value, immediate, and rt value (stores only).
- out_write_reg_en, out_write_reg_addr  out  1, 5  writeback request.

## Operation
- Decode classes:
  - ALU-immediate: ANDI, ORI, XORI, ADDI, ADDIU, SLTI, SLTIU, LUI.
  - Memory (macro only): LB, LH, LW, LBU, LHU, SB, SH, SW.
  - Anything else is "other".
- Register reads, driven combinationally from `inst` whenever in_valid=1:
  - ALU-immediate or memory: reg_read_en_1=1, reg_addr_1=rs.
  - Stores: reg_read_en_2=1, reg_addr_2=rt.
  - Otherwise each read enable is 0 and its address is 0.
- operand_2:
  - ANDI/ORI/XORI: the immediate zero-extended to DATA_WIDTH.
  - ADDI/ADDIU/SLTI/SLTIU and all memory ops: the immediate sign-extended to DATA_WIDTH.
  - LUI: {imm,16'b0} sign-extended from bit 31 to DATA_WIDTH.
  - Other: 0.
- operand_1 is reg_val_mux_data_1 for ALU-immediate and memory instructions, otherwise 0. store_data is reg_val_mux_data_2 for stores, otherwise 0.
- Writeback: write_reg_en=1 with write_reg_addr=rt for ALU-immediate and load instructions. Stores and other instructions have write_reg_en=0 and address 0.
- "Other" instructions are still enqueued, with all fields zero except out_op. This keeps program order and lets EX-side decoders merge streams.
- Queue:
  - Circular buffer with write pointer, read pointer and count register (log2(DEPTH)+1 bits).
  - Push when in_valid && in_ready. Pop when out_valid && out_ready.
  - Pointers wrap modulo DEPTH.
- Handshake:
  - in_ready = (count != DEPTH) && !flush && !rst. There is no pass-through when full.
  - out_valid = (count != 0).
  - Outputs always show the head entry. When the queue is empty, every out_* is 0.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- flush: count, read pointer and write pointer all go to 0. Flush has priority over a same-cycle push and pop, so the input beat is not accepted.
- Producers hold inst and in_valid stable until accepted. EX may deassert out_ready at any time.

## Timing
- Reset (rst=1 at an edge), and also reset asserted mid-operation:
  - count, pointers and all out_* become 0; in_ready=0 while rst=1.
  - Queued entries are discarded.
- Latency: an instruction accepted at edge N appears at the head after edge N, with out_valid=1 in cycle N+1 if the queue was empty.
- Throughput is one instruction per cycle when out_ready is held at 1.
- Full: count=DEPTH makes in_ready=0 in that cycle, even if out_ready=1. Input resumes in the cycle after a pop.
- Empty: out_valid=0. A pop attempt has no effect.
- Register read data is sampled only at the accepting edge. Later register changes do not alter queued operands.

## Configuration
- ID_IMM_MEM_EN defined:
  - Memory opcodes are decoded as described above.
  - out_mem=1 for them.
  - Stores use read port 2 and fill out_store_data.
- ID_IMM_MEM_EN undefined:
  - Memory opcodes are "other".
  - out_mem, reg_read_en_2, reg_addr_2 and out_store_data are tied to 0.

## Test plan
- ORI r2,r1,0x8001 with r1=0x0000_00F0, DATA_WIDTH=32, out_ready=1 -> next cycle out_operand_1=0xF0, out_operand_2=0x0000_8001, out_write_reg_addr=2, out_inst_immediate=1.
- DATA_WIDTH=64:
  - ADDI imm=0xFFFF -> out_operand_2=0xFFFF_FFFF_FFFF_FFFF.
  - LUI imm=0x8000 -> out_operand_2=0xFFFF_FFFF_8000_0000.
- DEPTH=2, out_ready=0, three valid beats -> first two accepted, in_ready=0 on the third. Raising out_ready pops in order; the third beat is accepted the cycle after the first pop.
- Queue holds 2 entries, then flush with in_valid=1 -> next cycle out_valid=0, count 0, input not accepted. rst asserted mid-stream gives the same result, with all outputs 0.
- With ID_IMM_MEM_EN: SW r5,-4(r3) with r3=0x100, r5=0xAB -> out_mem=1, out_operand_2=0xFFFF_FFFC, out_store_data=0xAB, out_write_reg_en=0.
- Without ID_IMM_MEM_EN, the same SW, and separately ADD, are enqueued with all fields 0 except out_op; ordering is preserved between surrounding ORIs.

Source files
------------

// File: rtl/id_imm_queue_if.sv
// id_imm_queue_if: bundles the ID-side instruction handshake, the register
// read port pair, flush, and the EX-side result handshake for id_imm_queue.
// slave = the queue itself; master = the surrounding pipeline / testbench.
interface id_imm_queue_if #(
  parameter int DATA_WIDTH = 32
);
  // control
  logic                  flush;
  // ID-side instruction handshake
  logic                  in_valid;
  logic                  in_ready;
  logic [31:0]           inst;
  // register read requests and combinational read data
  logic [4:0]            reg_addr_1;
  logic                  reg_read_en_1;
  logic [4:0]            reg_addr_2;
  logic                  reg_read_en_2;
  logic [DATA_WIDTH-1:0] reg_val_mux_data_1;
  logic [DATA_WIDTH-1:0] reg_val_mux_data_2;
  // EX-side head-of-queue handshake
  logic                  out_valid;
  logic                  out_ready;
  logic [5:0]            out_op;
  logic                  out_inst_immediate;
  logic                  out_mem;
  logic [DATA_WIDTH-1:0] out_operand_1;
  logic [DATA_WIDTH-1:0] out_operand_2;
  logic [DATA_WIDTH-1:0] out_store_data;
  logic                  out_write_reg_en;
  logic [4:0]            out_write_reg_addr;

  modport slave (
    input  flush, in_valid, inst, reg_val_mux_data_1, reg_val_mux_data_2, out_ready,
    output in_ready, reg_addr_1, reg_read_en_1, reg_addr_2, reg_read_en_2,
           out_valid, out_op, out_inst_immediate, out_mem, out_operand_1,
           out_operand_2, out_store_data, out_write_reg_en, out_write_reg_addr
  );

  modport master (
    output flush, in_valid, inst, reg_val_mux_data_1, reg_val_mux_data_2, out_ready,
    input  in_ready, reg_addr_1, reg_read_en_1, reg_addr_2, reg_read_en_2,
           out_valid, out_op, out_inst_immediate, out_mem, out_operand_1,
           out_operand_2, out_store_data, out_write_reg_en, out_write_reg_addr
  );
endinterface

// File: rtl/id_imm_queue.sv
// Purpose: decode I-type ALU (and, with ID_IMM_MEM_EN, load/store) instructions,
//          capture rs/rt data and the extended immediate into a DEPTH-entry queue.
// Latency: accepted at edge N -> at queue head (out_valid=1) in cycle N+1 when empty.
// Backpressure: in_ready=0 when full (no pass-through), during flush or rst; head holds until out_ready.
// Ports: clk, rst (sync, active high); bus (id_imm_queue_if.slave) carries flush,
//        in_valid/in_ready/inst, reg read requests + data, out_valid/out_ready and out_* fields.
// Config: `define ID_IMM_MEM_EN enables load/store decode, read port 2 and out_mem/out_store_data.
module id_imm_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input  logic           clk,
  input  logic           rst,
  id_imm_queue_if.slave  bus
);

`ifdef ID_IMM_MEM_EN
  localparam logic MEM_EN = 1'b1;
`else
  localparam logic MEM_EN = 1'b0;
`endif

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [5:0] OP_ADDI  = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C, OP_ORI   = 6'h0D, OP_XORI = 6'h0E, OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20, OP_LH    = 6'h21, OP_LW   = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24, OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28, OP_SH    = 6'h29, OP_SW   = 6'h2B;

  typedef struct packed {
    logic [5:0]            op;
    logic                  imm;
    logic                  mem;
    logic [DATA_WIDTH-1:0] op1;
    logic [DATA_WIDTH-1:0] op2;
    logic [DATA_WIDTH-1:0] sdata;
    logic                  wen;
    logic [4:0]            waddr;
  } entry_t;

  // instruction fields
  logic [5:0]         opc;
  logic [4:0]         rs;
  logic [4:0]         rt;
  logic [15:0]        imm;
  logic signed [15:0] imm_s;
  logic signed [31:0] lui_s;

  assign opc   = bus.inst[31:26];
  assign rs    = bus.inst[25:21];
  assign rt    = bus.inst[20:16];
  assign imm   = bus.inst[15:0];
  assign imm_s = bus.inst[15:0];
  // LUI result is formed at 32 bits first, then sign-extended from bit 31
  assign lui_s = {bus.inst[15:0], 16'h0000};

  logic is_alu, is_zext, is_lui, is_load, is_store, is_mem;

  always_comb begin
    is_alu   = 1'b0;
    is_zext  = 1'b0;
    is_lui   = 1'b0;
    is_load  = 1'b0;
    is_store = 1'b0;
    case (opc)
      OP_ANDI, OP_ORI, OP_XORI: begin
        is_alu  = 1'b1;
        is_zext = 1'b1;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: is_alu = 1'b1;
      OP_LUI: begin
        is_alu = 1'b1;
        is_lui = 1'b1;
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: is_load  = MEM_EN;
      OP_SB, OP_SH, OP_SW:                 is_store = MEM_EN;
      default: ;
    endcase
  end

  assign is_mem = is_load | is_store;

  // register read requests, only while an instruction is presented
  always_comb begin
    bus.reg_read_en_1 = bus.in_valid && (is_alu || is_mem);
    bus.reg_addr_1    = bus.reg_read_en_1 ? rs : 5'd0;
    bus.reg_read_en_2 = bus.in_valid && is_store;
    bus.reg_addr_2    = bus.reg_read_en_2 ? rt : 5'd0;
  end

  // entry built from the current instruction; "other" keeps only the opcode
  entry_t new_entry;

  always_comb begin
    new_entry     = '0;
    new_entry.op  = opc;
    new_entry.imm = is_alu;
    new_entry.mem = is_mem;
    if (is_alu || is_mem)
      new_entry.op1 = bus.reg_val_mux_data_1;
    if (is_zext)
      new_entry.op2 = DATA_WIDTH'(imm);
    else if (is_lui)
      new_entry.op2 = DATA_WIDTH'(lui_s);
    else if (is_alu || is_mem)
      new_entry.op2 = DATA_WIDTH'(imm_s);
    if (is_store)
      new_entry.sdata = bus.reg_val_mux_data_2;
    if (is_alu || is_load) begin
      new_entry.wen   = 1'b1;
      new_entry.waddr = rt;
    end
  end

  // circular buffer
  entry_t           queue_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;

  assign bus.in_ready  = (count != CNT_W'(DEPTH)) && !bus.flush && !rst;
  assign bus.out_valid = (count != '0);
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        queue_q[wr_ptr] <= new_entry;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // head entry, blanked to zero when empty
  entry_t head;

  always_comb begin
    head = bus.out_valid ? queue_q[rd_ptr] : '0;
    bus.out_op             = head.op;
    bus.out_inst_immediate = head.imm;
    bus.out_mem            = head.mem;
    bus.out_operand_1      = head.op1;
    bus.out_operand_2      = head.op2;
    bus.out_store_data     = head.sdata;
    bus.out_write_reg_en   = head.wen;
    bus.out_write_reg_addr = head.waddr;
  end

endmodule

// File: tb/tb_id_imm_queue.sv
// Directed bench for id_imm_queue: a 32-bit DEPTH=2 instance driven from a
// vector table plus multi-cycle sequences, and a 64-bit instance for extension.
module tb_id_imm_queue;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  id_imm_queue_if #(.DATA_WIDTH(32)) bus32 ();
  id_imm_queue_if #(.DATA_WIDTH(64)) bus64 ();

  id_imm_queue #(.DATA_WIDTH(32), .DEPTH(2)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
  id_imm_queue #(.DATA_WIDTH(64), .DEPTH(2)) dut64 (.clk(clk), .rst(rst), .bus(bus64));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] r1;
    logic [31:0] r2;
    logic        en1;
    logic [4:0]  a1;
    logic        en2;
    logic [4:0]  a2;
    logic [5:0]  op;
    logic        immf;
    logic        mem;
    logic [31:0] o1;
    logic [31:0] o2;
    logic [31:0] sd;
    logic        wen;
    logic [4:0]  wa;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive32(input logic [31:0] inst, input logic [31:0] r1);
    bus32.inst               = inst;
    bus32.reg_val_mux_data_1 = r1;
    bus32.in_valid           = 1'b1;
  endtask

  task automatic run64(input string nm, input logic [31:0] inst, input logic [63:0] r1,
                       input logic [63:0] exp_op1, input logic [63:0] exp_op2);
    bus64.inst               = inst;
    bus64.reg_val_mux_data_1 = r1;
    bus64.in_valid           = 1'b1;
    bus64.out_ready          = 1'b1;
    tick();
    bus64.in_valid = 1'b0;
    chk({nm, ".valid"}, 64'(bus64.out_valid), 64'd1);
    chk({nm, ".op1"}, bus64.out_operand_1, exp_op1);
    chk({nm, ".op2"}, bus64.out_operand_2, exp_op2);
    tick();
  endtask

  // stream-order expectations: ORI r2, ADD, SW, ORI r3
  logic [31:0] s_inst [4];
  logic [5:0]  s_op   [4];
  logic        s_wen  [4];
  logic [4:0]  s_wa   [4];
  logic [31:0] s_op2  [4];
  logic        s_mem  [4];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    total = 0;
    bad   = 0;

    // inst, r1, r2, en1, a1, en2, a2, op, immf, mem, o1, o2, sd, wen, wa
    vecs[0] = '{itype(6'h0D, 5'd1, 5'd2, 16'h8001), 32'hF0, 32'h0, 1'b1, 5'd1, 1'b0, 5'd0,
                6'h0D, 1'b1, 1'b0, 32'hF0, 32'h0000_8001, 32'h0, 1'b1, 5'd2};
    vecs[1] = '{itype(6'h0C, 5'd3, 5'd7, 16'hFFFF), 32'h1234_5678, 32'h0, 1'b1, 5'd3, 1'b0, 5'd0,
                6'h0C, 1'b1, 1'b0, 32'h1234_5678, 32'h0000_FFFF, 32'h0, 1'b1, 5'd7};
    vecs[2] = '{itype(6'h08, 5'd5, 5'd4, 16'hFFFF), 32'hA, 32'h0, 1'b1, 5'd5, 1'b0, 5'd0,
                6'h08, 1'b1, 1'b0, 32'hA, 32'hFFFF_FFFF, 32'h0, 1'b1, 5'd4};
    vecs[3] = '{itype(6'h0B, 5'd10, 5'd9, 16'h7FFF), 32'h3, 32'h0, 1'b1, 5'd10, 1'b0, 5'd0,
                6'h0B, 1'b1, 1'b0, 32'h3, 32'h0000_7FFF, 32'h0, 1'b1, 5'd9};
    vecs[4] = '{itype(6'h0F, 5'd0, 5'd6, 16'h8000), 32'h55, 32'h0, 1'b1, 5'd0, 1'b0, 5'd0,
                6'h0F, 1'b1, 1'b0, 32'h55, 32'h8000_0000, 32'h0, 1'b1, 5'd6};
    vecs[5] = '{itype(6'h0E, 5'd30, 5'd31, 16'h1234), 32'hFFFF_0000, 32'h0, 1'b1, 5'd30, 1'b0, 5'd0,
                6'h0E, 1'b1, 1'b0, 32'hFFFF_0000, 32'h0000_1234, 32'h0, 1'b1, 5'd31};
    vecs[6] = '{itype(6'h09, 5'd2, 5'd1, 16'h8000), 32'h7, 32'h0, 1'b1, 5'd2, 1'b0, 5'd0,
                6'h09, 1'b1, 1'b0, 32'h7, 32'hFFFF_8000, 32'h0, 1'b1, 5'd1};
    vecs[7] = '{{6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20}, 32'h77, 32'h88, 1'b0, 5'd0, 1'b0, 5'd0,
                6'h00, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0};
`ifdef ID_IMM_MEM_EN
    vecs[8] = '{itype(6'h2B, 5'd3, 5'd5, 16'hFFFC), 32'h100, 32'hAB, 1'b1, 5'd3, 1'b1, 5'd5,
                6'h2B, 1'b0, 1'b1, 32'h100, 32'hFFFF_FFFC, 32'hAB, 1'b0, 5'd0};
    vecs[9] = '{itype(6'h23, 5'd2, 5'd8, 16'h0010), 32'h2000, 32'h99, 1'b1, 5'd2, 1'b0, 5'd0,
                6'h23, 1'b0, 1'b1, 32'h2000, 32'h10, 32'h0, 1'b1, 5'd8};
`else
    vecs[8] = '{itype(6'h2B, 5'd3, 5'd5, 16'hFFFC), 32'h100, 32'hAB, 1'b0, 5'd0, 1'b0, 5'd0,
                6'h2B, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0};
    vecs[9] = '{itype(6'h23, 5'd2, 5'd8, 16'h0010), 32'h2000, 32'h99, 1'b0, 5'd0, 1'b0, 5'd0,
                6'h23, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0};
`endif

    // ---- reset state ----
    rst = 1'b1;
    bus32.flush = 1'b0; bus32.in_valid = 1'b0; bus32.inst = '0; bus32.out_ready = 1'b0;
    bus32.reg_val_mux_data_1 = '0; bus32.reg_val_mux_data_2 = '0;
    bus64.flush = 1'b0; bus64.in_valid = 1'b0; bus64.inst = '0; bus64.out_ready = 1'b0;
    bus64.reg_val_mux_data_1 = '0; bus64.reg_val_mux_data_2 = '0;
    tick();
    tick();
    chk("rst.in_ready", 64'(bus32.in_ready), 64'd0);
    chk("rst.out_valid", 64'(bus32.out_valid), 64'd0);
    chk("rst.out_op", 64'(bus32.out_op), 64'd0);
    chk("rst.out_operand_2", 64'(bus32.out_operand_2), 64'd0);
    chk("rst.out_write_reg_en", 64'(bus32.out_write_reg_en), 64'd0);
    rst = 1'b0;
    #1;
    chk("rst_release.in_ready", 64'(bus32.in_ready), 64'd1);

    // ---- table-driven single-instruction decode ----
    bus32.out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      bus32.inst               = vecs[i].inst;
      bus32.reg_val_mux_data_1 = vecs[i].r1;
      bus32.reg_val_mux_data_2 = vecs[i].r2;
      bus32.in_valid           = 1'b1;
      #1;
      chk($sformatf("v%0d.in_ready", i), 64'(bus32.in_ready), 64'd1);
      chk($sformatf("v%0d.en1", i), 64'(bus32.reg_read_en_1), 64'(vecs[i].en1));
      chk($sformatf("v%0d.a1", i), 64'(bus32.reg_addr_1), 64'(vecs[i].a1));
      chk($sformatf("v%0d.en2", i), 64'(bus32.reg_read_en_2), 64'(vecs[i].en2));
      chk($sformatf("v%0d.a2", i), 64'(bus32.reg_addr_2), 64'(vecs[i].a2));
      tick();
      bus32.in_valid           = 1'b0;
      bus32.reg_val_mux_data_1 = 32'hDEAD_BEEF;
      bus32.reg_val_mux_data_2 = 32'hDEAD_BEEF;
      #1;
      chk($sformatf("v%0d.out_valid", i), 64'(bus32.out_valid), 64'd1);
      chk($sformatf("v%0d.op", i), 64'(bus32.out_op), 64'(vecs[i].op));
      chk($sformatf("v%0d.immf", i), 64'(bus32.out_inst_immediate), 64'(vecs[i].immf));
      chk($sformatf("v%0d.mem", i), 64'(bus32.out_mem), 64'(vecs[i].mem));
      chk($sformatf("v%0d.op1", i), 64'(bus32.out_operand_1), 64'(vecs[i].o1));
      chk($sformatf("v%0d.op2", i), 64'(bus32.out_operand_2), 64'(vecs[i].o2));
      chk($sformatf("v%0d.sd", i), 64'(bus32.out_store_data), 64'(vecs[i].sd));
      chk($sformatf("v%0d.wen", i), 64'(bus32.out_write_reg_en), 64'(vecs[i].wen));
      chk($sformatf("v%0d.wa", i), 64'(bus32.out_write_reg_addr), 64'(vecs[i].wa));
      tick();
      chk($sformatf("v%0d.drained", i), 64'(bus32.out_valid), 64'd0);
    end

    // ---- 64-bit immediate extension ----
    run64("w64.addi", itype(6'h08, 5'd1, 5'd2, 16'hFFFF), 64'h1_0000_0001,
          64'h1_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF);
    run64("w64.lui", itype(6'h0F, 5'd0, 5'd2, 16'h8000), 64'h0,
          64'h0, 64'hFFFF_FFFF_8000_0000);
    run64("w64.ori", itype(6'h0D, 5'd1, 5'd2, 16'h8001), 64'h5,
          64'h5, 64'h0000_0000_0000_8001);

    // ---- full queue backpressure and ordered drain ----
    bus32.out_ready = 1'b0;
    drive32(itype(6'h0D, 5'd1, 5'd11, 16'h0011), 32'h1);
    #1;
    chk("full.a_ready", 64'(bus32.in_ready), 64'd1);
    tick();
    drive32(itype(6'h0D, 5'd1, 5'd12, 16'h0012), 32'h2);
    #1;
    chk("full.b_ready", 64'(bus32.in_ready), 64'd1);
    tick();
    drive32(itype(6'h0D, 5'd1, 5'd13, 16'h0013), 32'h3);
    #1;
    chk("full.c_blocked", 64'(bus32.in_ready), 64'd0);
    tick();
    chk("full.still_blocked", 64'(bus32.in_ready), 64'd0);
    chk("full.head_a", 64'(bus32.out_write_reg_addr), 64'd11);
    bus32.out_ready = 1'b1;
    #1;
    chk("full.no_passthrough", 64'(bus32.in_ready), 64'd0);
    tick();
    chk("full.head_b", 64'(bus32.out_write_reg_addr), 64'd12);
    chk("full.c_ready_after_pop", 64'(bus32.in_ready), 64'd1);
    tick();
    bus32.in_valid = 1'b0;
    #1;
    chk("full.head_c", 64'(bus32.out_write_reg_addr), 64'd13);
    chk("full.head_c_op1", 64'(bus32.out_operand_1), 64'd3);
    tick();
    chk("full.drained", 64'(bus32.out_valid), 64'd0);

    // ---- flush with two queued entries ----
    bus32.out_ready = 1'b0;
    drive32(itype(6'h0D, 5'd1, 5'd21, 16'h0021), 32'h0); tick();
    drive32(itype(6'h0D, 5'd1, 5'd22, 16'h0022), 32'h0); tick();
    chk("flush2.pre_valid", 64'(bus32.out_valid), 64'd1);
    drive32(itype(6'h0D, 5'd1, 5'd23, 16'h0023), 32'h0);
    bus32.flush = 1'b1;
    #1;
    chk("flush2.in_ready", 64'(bus32.in_ready), 64'd0);
    tick();
    bus32.flush    = 1'b0;
    bus32.in_valid = 1'b0;
    #1;
    chk("flush2.out_valid", 64'(bus32.out_valid), 64'd0);
    chk("flush2.out_op", 64'(bus32.out_op), 64'd0);
    chk("flush2.out_op2", 64'(bus32.out_operand_2), 64'd0);

    // ---- flush beats a same-cycle push when not full ----
    drive32(itype(6'h0D, 5'd1, 5'd24, 16'h0024), 32'h0); tick();
    drive32(itype(6'h0D, 5'd1, 5'd25, 16'h0025), 32'h0);
    bus32.flush     = 1'b1;
    bus32.out_ready = 1'b1;
    #1;
    chk("flush1.in_ready", 64'(bus32.in_ready), 64'd0);
    tick();
    bus32.flush    = 1'b0;
    bus32.in_valid = 1'b0;
    #1;
    chk("flush1.out_valid", 64'(bus32.out_valid), 64'd0);
    // pointers restart at zero: next push is the new head
    bus32.out_ready = 1'b0;
    drive32(itype(6'h0D, 5'd1, 5'd26, 16'h0026), 32'h0); tick();
    bus32.in_valid = 1'b0;
    #1;
    chk("flush1.refill_head", 64'(bus32.out_write_reg_addr), 64'd26);
    bus32.out_ready = 1'b1;
    tick();
    chk("flush1.refill_drained", 64'(bus32.out_valid), 64'd0);

    // ---- reset mid-stream ----
    bus32.out_ready = 1'b0;
    drive32(itype(6'h0D, 5'd1, 5'd27, 16'h0027), 32'h9); tick();
    drive32(itype(6'h0D, 5'd1, 5'd28, 16'h0028), 32'h9);
    rst = 1'b1;
    #1;
    chk("midrst.in_ready", 64'(bus32.in_ready), 64'd0);
    tick();
    chk("midrst.out_valid", 64'(bus32.out_valid), 64'd0);
    chk("midrst.out_op", 64'(bus32.out_op), 64'd0);
    chk("midrst.out_imm", 64'(bus32.out_inst_immediate), 64'd0);
    chk("midrst.out_op1", 64'(bus32.out_operand_1), 64'd0);
    chk("midrst.out_op2", 64'(bus32.out_operand_2), 64'd0);
    chk("midrst.out_wen", 64'(bus32.out_write_reg_en), 64'd0);
    chk("midrst.out_wa", 64'(bus32.out_write_reg_addr), 64'd0);
    chk("midrst.in_ready_held", 64'(bus32.in_ready), 64'd0);
    bus32.in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("midrst.release", 64'(bus32.in_ready), 64'd1);

    // ---- operands captured at the accepting edge only ----
    drive32(itype(6'h0D, 5'd1, 5'd29, 16'h0001), 32'h11); tick();
    bus32.in_valid           = 1'b0;
    bus32.reg_val_mux_data_1 = 32'h99;
    #1;
    chk("sample.op1_held", 64'(bus32.out_operand_1), 64'h11);
    bus32.out_ready = 1'b1;
    tick();
    chk("sample.drained", 64'(bus32.out_valid), 64'd0);

    // ---- back-to-back stream, "other" ops kept in order ----
    s_inst[0] = itype(6'h0D, 5'd1, 5'd2, 16'h0005);
    s_op[0] = 6'h0D; s_wen[0] = 1'b1; s_wa[0] = 5'd2; s_op2[0] = 32'h5; s_mem[0] = 1'b0;
    s_inst[1] = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20};
    s_op[1] = 6'h00; s_wen[1] = 1'b0; s_wa[1] = 5'd0; s_op2[1] = 32'h0; s_mem[1] = 1'b0;
    s_inst[2] = itype(6'h2B, 5'd3, 5'd5, 16'hFFFC);
    s_op[2] = 6'h2B; s_wen[2] = 1'b0; s_wa[2] = 5'd0;
`ifdef ID_IMM_MEM_EN
    s_op2[2] = 32'hFFFF_FFFC; s_mem[2] = 1'b1;
`else
    s_op2[2] = 32'h0; s_mem[2] = 1'b0;
`endif
    s_inst[3] = itype(6'h0D, 5'd1, 5'd3, 16'h0006);
    s_op[3] = 6'h0D; s_wen[3] = 1'b1; s_wa[3] = 5'd3; s_op2[3] = 32'h6; s_mem[3] = 1'b0;

    bus32.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive32(s_inst[k], 32'h100);
      bus32.reg_val_mux_data_2 = 32'hAB;
      #1;
      chk($sformatf("stream%0d.in_ready", k), 64'(bus32.in_ready), 64'd1);
      tick();
      chk($sformatf("stream%0d.op", k), 64'(bus32.out_op), 64'(s_op[k]));
      chk($sformatf("stream%0d.wen", k), 64'(bus32.out_write_reg_en), 64'(s_wen[k]));
      chk($sformatf("stream%0d.wa", k), 64'(bus32.out_write_reg_addr), 64'(s_wa[k]));
      chk($sformatf("stream%0d.op2", k), 64'(bus32.out_operand_2), 64'(s_op2[k]));
      chk($sformatf("stream%0d.mem", k), 64'(bus32.out_mem), 64'(s_mem[k]));
    end
    bus32.in_valid = 1'b0;
    tick();
    chk("stream.drained", 64'(bus32.out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
